// File: rtl/accumulation_buffer_pkg.sv
// -----------------------------------------------------------------------------
// accumulation_buffer_pkg
//   Shared definitions for the accumulation buffer and its neighbours.
//   - Default lane width and lane count, shared with the mac cell and the
//     systolic array top, so all three agree on the partial-sum vector shape.
//   - Drain FSM state encoding.
// -----------------------------------------------------------------------------
package accumulation_buffer_pkg;

    // Default partial-sum vector shape (one lane per array column)
    localparam int OFMAP_WIDTH_DEF = 8;
    localparam int ARRAY_WIDTH_DEF = 4;

    // Drain FSM states
    typedef logic drain_state_t;
    localparam drain_state_t DRAIN_IDLE   = 1'b0;
    localparam drain_state_t DRAIN_ACTIVE = 1'b1;

endpackage : accumulation_buffer_pkg

// File: rtl/accumulation_buffer_bank.sv
// -----------------------------------------------------------------------------
// accumulation_bank
//   One bank of the double-buffered accumulator: DEPTH entries of ARRAY_WIDTH
//   lanes, each OFMAP_WIDTH bits, held in flops.
//
// Ports
//   clk         in   clock
//   rst_n       in   synchronous active-low reset, clears every entry
//   wen         in   write enable
//   waddr       in   write entry address
//   accumulate  in   1: entry <= entry + wdata (per lane); 0: entry <= wdata
//   wdata       in   write vector, lane i at [i*OFMAP_WIDTH +: OFMAP_WIDTH]
//   raddr       in   combinational read address
//   rdata       out  mem[raddr]
//   clr         in   clear entry clr_addr to zero
//   clr_addr    in   entry address to clear
// -----------------------------------------------------------------------------
module accumulation_bank
    import accumulation_buffer_pkg::*;
#(
    parameter int OFMAP_WIDTH = OFMAP_WIDTH_DEF,
    parameter int ARRAY_WIDTH = ARRAY_WIDTH_DEF,
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wen,
    input  logic [ADDR_WIDTH-1:0]              waddr,
    input  logic                               accumulate,
    input  logic [ARRAY_WIDTH*OFMAP_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0]              raddr,
    output logic [ARRAY_WIDTH*OFMAP_WIDTH-1:0] rdata,
    input  logic                               clr,
    input  logic [ADDR_WIDTH-1:0]              clr_addr
);

    localparam int VEC_WIDTH = ARRAY_WIDTH * OFMAP_WIDTH;

    logic [VEC_WIDTH-1:0] mem [DEPTH];
    logic [VEC_WIDTH-1:0] wr_vec;

    // Lane-wise two's-complement add. Each lane wraps modulo 2^OFMAP_WIDTH
    // and no carry crosses a lane boundary.
    function automatic logic [VEC_WIDTH-1:0] lane_add(
        input logic [VEC_WIDTH-1:0] a,
        input logic [VEC_WIDTH-1:0] b
    );
        logic [VEC_WIDTH-1:0]          s;
        logic signed [OFMAP_WIDTH-1:0] la;
        logic signed [OFMAP_WIDTH-1:0] lb;
        logic signed [OFMAP_WIDTH-1:0] ls;
        s = '0;
        for (int i = 0; i < ARRAY_WIDTH; i++) begin
            la = a[i*OFMAP_WIDTH +: OFMAP_WIDTH];
            lb = b[i*OFMAP_WIDTH +: OFMAP_WIDTH];
            ls = la + lb;
            s[i*OFMAP_WIDTH +: OFMAP_WIDTH] = ls;
        end
        return s;
    endfunction

    // Read-modify-write: the stored entry is read combinationally so that
    // back-to-back accumulates to one address see the previous edge's result.
    always_comb begin
        wr_vec = wdata;
        if (accumulate) begin
            wr_vec = lane_add(mem[waddr], wdata);
        end
    end

    assign rdata = mem[raddr];

    // A bank is either written or cleared in a given cycle by the top; should
    // both ever hit one entry, the write wins since it is issued last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (clr) begin
                mem[clr_addr] <= '0;
            end
            if (wen) begin
                mem[waddr] <= wr_vec;
            end
        end
    end

endmodule : accumulation_bank

// File: rtl/accumulation_buffer.sv
// -----------------------------------------------------------------------------
// accumulation_buffer
//   Double-buffered output accumulator placed below the systolic array. One
//   bank accumulates ofmap partial sums (overwrite or add per lane) while the
//   other is drained, entry by entry, over a valid/ready stream. Drained
//   entries are cleared, so a bank always returns to writing all-zero.
//
// Ports
//   clk           in   clock
//   rst_n         in   synchronous active-low reset (clears both banks)
//   wen           in   write a vector into the write bank
//   waddr         in   write entry address
//   accumulate    in   1: add wdata to the stored entry; 0: overwrite
//   wdata         in   lane i at [i*OFMAP_WIDTH +: OFMAP_WIDTH]
//   switch_banks  in   swap bank roles and start a drain (accepted in idle)
//   switch_ready  out  drain idle, a switch is accepted this cycle
//   rdata         out  entry being drained (zero when idle)
//   rvalid        out  rdata valid
//   rready        in   downstream accepts rdata
// -----------------------------------------------------------------------------
module accumulation_buffer
    import accumulation_buffer_pkg::*;
#(
    parameter int OFMAP_WIDTH = OFMAP_WIDTH_DEF,
    parameter int ARRAY_WIDTH = ARRAY_WIDTH_DEF,
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wen,
    input  logic [ADDR_WIDTH-1:0]              waddr,
    input  logic                               accumulate,
    input  logic [ARRAY_WIDTH*OFMAP_WIDTH-1:0] wdata,
    input  logic                               switch_banks,
    output logic                               switch_ready,
    output logic [ARRAY_WIDTH*OFMAP_WIDTH-1:0] rdata,
    output logic                               rvalid,
    input  logic                               rready
);

    localparam int VEC_WIDTH = ARRAY_WIDTH * OFMAP_WIDTH;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("accumulation_buffer: DEPTH must be a power of two >= 2");
        end
    endgenerate

    drain_state_t          state;
    drain_state_t          state_next;
    logic                  write_bank;
    logic [ADDR_WIDTH-1:0] drain_addr;

    logic                  switch_accept;
    logic                  handshake;
    logic                  last_entry;

    logic                  bank0_wen;
    logic                  bank1_wen;
    logic                  bank0_clr;
    logic                  bank1_clr;
    logic [VEC_WIDTH-1:0]  bank0_rdata;
    logic [VEC_WIDTH-1:0]  bank1_rdata;
    logic [VEC_WIDTH-1:0]  read_vec;

    assign last_entry = (drain_addr == ADDR_WIDTH'(DEPTH - 1));

    // Writes always follow write_bank as it stands this cycle, so a write
    // issued together with an accepted switch lands in the bank about to be
    // drained.
    assign bank0_wen = wen && (write_bank == 1'b0);
    assign bank1_wen = wen && (write_bank == 1'b1);

    // The read bank is the one not selected by write_bank.
    assign bank0_clr = handshake && (write_bank == 1'b1);
    assign bank1_clr = handshake && (write_bank == 1'b0);
    assign read_vec  = write_bank ? bank0_rdata : bank1_rdata;

    accumulation_bank #(
        .OFMAP_WIDTH (OFMAP_WIDTH),
        .ARRAY_WIDTH (ARRAY_WIDTH),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_bank0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .wen        (bank0_wen),
        .waddr      (waddr),
        .accumulate (accumulate),
        .wdata      (wdata),
        .raddr      (drain_addr),
        .rdata      (bank0_rdata),
        .clr        (bank0_clr),
        .clr_addr   (drain_addr)
    );

    accumulation_bank #(
        .OFMAP_WIDTH (OFMAP_WIDTH),
        .ARRAY_WIDTH (ARRAY_WIDTH),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_bank1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .wen        (bank1_wen),
        .waddr      (waddr),
        .accumulate (accumulate),
        .wdata      (wdata),
        .raddr      (drain_addr),
        .rdata      (bank1_rdata),
        .clr        (bank1_clr),
        .clr_addr   (drain_addr)
    );

    // Drain FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= DRAIN_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Drain FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            DRAIN_IDLE: begin
                if (switch_banks) begin
                    state_next = DRAIN_ACTIVE;
                end
            end
            DRAIN_ACTIVE: begin
                if (rready && last_entry) begin
                    state_next = DRAIN_IDLE;
                end
            end
            default: state_next = DRAIN_IDLE;
        endcase
    end

    // Drain FSM: outputs
    always_comb begin
        switch_ready  = 1'b0;
        switch_accept = 1'b0;
        rvalid        = 1'b0;
        handshake     = 1'b0;
        rdata         = '0;
        case (state)
            DRAIN_IDLE: begin
                switch_ready  = 1'b1;
                switch_accept = switch_banks;
            end
            DRAIN_ACTIVE: begin
                rvalid    = 1'b1;
                rdata     = read_vec;
                handshake = rready;
            end
            default: ;
        endcase
    end

    // Bank select and drain pointer. A switch is only accepted in idle and
    // the pointer only moves on a handshake, so a stalled drain holds rdata.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_bank <= 1'b0;
            drain_addr <= '0;
        end else if (switch_accept) begin
            write_bank <= ~write_bank;
            drain_addr <= '0;
        end else if (handshake) begin
            if (last_entry) begin
                drain_addr <= '0;
            end else begin
                drain_addr <= drain_addr + 1'b1;
            end
        end
    end

endmodule : accumulation_buffer

// File: tb/tb_accumulation_buffer.sv
// -----------------------------------------------------------------------------
// tb_accumulation_buffer
//   Scoreboard bench: stimulus pushes the expected drain contents into a
//   queue; a monitor pops and compares on every rvalid && rready cycle and
//   checks that rdata/rvalid hold during stalls.
// -----------------------------------------------------------------------------
module tb_accumulation_buffer;

    localparam int OW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int ADRW  = 4;

    logic            clk;
    logic            rst_n;
    logic            wen;
    logic [ADRW-1:0] waddr;
    logic            accumulate;
    logic [AW*OW-1:0] wdata;
    logic            switch_banks;
    logic            switch_ready;
    logic [AW*OW-1:0] rdata;
    logic            rvalid;
    logic            rready;

    accumulation_buffer #(
        .OFMAP_WIDTH (OW),
        .ARRAY_WIDTH (AW),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (ADRW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wen          (wen),
        .waddr        (waddr),
        .accumulate   (accumulate),
        .wdata        (wdata),
        .switch_banks (switch_banks),
        .switch_ready (switch_ready),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rready       (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [AW*OW-1:0] exp_q [$];
    logic [AW*OW-1:0] exp_bank [DEPTH];
    int               vcount;
    int               pop_idx;

    function automatic logic [AW*OW-1:0] pk(input int a, input int b, input int c, input int d);
        logic [7:0] la, lb, lc, ld;
        la = a[7:0];
        lb = b[7:0];
        lc = c[7:0];
        ld = d[7:0];
        return {ld, lc, lb, la};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: compare on handshakes, check holding during stalls.
    logic             prev_stall;
    logic [AW*OW-1:0] prev_data;
    initial begin
        prev_stall = 1'b0;
        prev_data  = '0;
        vcount     = 0;
        pop_idx    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (rvalid) vcount++;
                if (prev_stall) begin
                    check("stall_rvalid_hold", {31'b0, rvalid}, 32'd1);
                    check("stall_rdata_hold", rdata, prev_data);
                end
                if (rvalid && rready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h, expected no output", rdata);
                    end else begin
                        check($sformatf("drain_entry_%0d", pop_idx % DEPTH), rdata, exp_q.pop_front());
                    end
                    pop_idx++;
                end
                prev_stall = rvalid && !rready;
                prev_data  = rdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic acc, input logic [AW*OW-1:0] d);
        wen        = 1'b1;
        waddr      = addr[ADRW-1:0];
        accumulate = acc;
        wdata      = d;
        tick();
        wen        = 1'b0;
        accumulate = 1'b0;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < DEPTH; i++) exp_bank[i] = '0;
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_bank[i]);
        pop_idx = 0;
    endtask

    task automatic do_switch();
        switch_banks = 1'b1;
        tick();
        switch_banks = 1'b0;
    endtask

    // Drive rready with a pattern (0: always 1, 1: 1,0,0 repeating) until
    // the drain is finished and the scoreboard is empty, within a bound.
    task automatic wait_drain(input int mode, input string name);
        int c;
        for (c = 0; c < 300; c++) begin
            if (switch_ready && exp_q.size() == 0) break;
            rready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            tick();
        end
        rready = 1'b0;
        if (c >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d left, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic full_drain(input int mode, input string name);
        push_exp(DEPTH);
        rready = (mode == 0);
        do_switch();
        wait_drain(mode, name);
    endtask

    initial begin
        rst_n        = 1'b0;
        wen          = 1'b0;
        waddr        = '0;
        accumulate   = 1'b0;
        wdata        = '0;
        switch_banks = 1'b0;
        rready       = 1'b0;

        // Reset
        tick();
        tick();
        check("reset_rvalid", {31'b0, rvalid}, 32'd0);
        check("reset_switch_ready", {31'b0, switch_ready}, 32'd1);
        check("reset_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        tick();
        clear_exp();
        full_drain(0, "reset_drain");

        // Overwrite then accumulate, rvalid for exactly DEPTH cycles
        wr(3, 1'b0, pk(1, 2, 3, 4));
        wr(3, 1'b1, pk(10, 10, 10, 10));
        clear_exp();
        exp_bank[3] = pk(11, 12, 13, 14);
        vcount = 0;
        full_drain(0, "ovr_acc");
        check("ovr_acc_rvalid_cycles", vcount, 32'd16);

        // Lane wrap: 100 + 200 = 44 in lane 0, lane 1 untouched
        wr(0, 1'b0, pk(100, 7, 0, 0));
        wr(0, 1'b1, pk(200, 0, 0, 0));
        wr(15, 1'b0, pk(255, 128, 1, 127));
        wr(15, 1'b1, pk(1, 128, 255, 1));
        clear_exp();
        exp_bank[0]  = pk(44, 7, 0, 0);
        exp_bank[15] = pk(0, 0, 0, 128);
        full_drain(0, "lane_wrap");

        // Backpressure with distinct entries
        for (int i = 0; i < DEPTH; i++) wr(i, 1'b0, pk(i, i + 16, i + 32, i + 48));
        for (int i = 0; i < DEPTH; i++) exp_bank[i] = pk(i, i + 16, i + 32, i + 48);
        full_drain(1, "backpressure");

        // Concurrent activity: ignored switch and writes during drain
        wr(2, 1'b0, pk(5, 6, 7, 8));
        clear_exp();
        exp_bank[2] = pk(5, 6, 7, 8);
        push_exp(DEPTH);
        rready = 1'b1;
        do_switch();
        switch_banks = 1'b1;
        wen          = 1'b1;
        waddr        = 4'd5;
        accumulate   = 1'b0;
        wdata        = pk(21, 22, 23, 24);
        check("drain_switch_ready", {31'b0, switch_ready}, 32'd0);
        tick();
        switch_banks = 1'b0;
        wen          = 1'b0;
        check("drain_switch_ready_2", {31'b0, switch_ready}, 32'd0);
        wait_drain(0, "concurrent_a");
        clear_exp();
        exp_bank[5] = pk(21, 22, 23, 24);
        full_drain(0, "concurrent_b");
        clear_exp();
        full_drain(0, "concurrent_zero");

        // Write together with an accepted switch
        wr(1, 1'b0, pk(3, 3, 3, 3));
        clear_exp();
        exp_bank[1] = pk(3, 3, 3, 3);
        exp_bank[9] = pk(9, 8, 7, 6);
        push_exp(DEPTH);
        rready       = 1'b1;
        wen          = 1'b1;
        waddr        = 4'd9;
        wdata        = pk(9, 8, 7, 6);
        switch_banks = 1'b1;
        tick();
        wen          = 1'b0;
        switch_banks = 1'b0;
        wait_drain(0, "wen_with_switch");

        // Reset at drain entry 7
        wr(3, 1'b0, pk(1, 1, 1, 1));
        wr(10, 1'b0, pk(2, 2, 2, 2));
        clear_exp();
        exp_bank[3] = pk(1, 1, 1, 1);
        push_exp(7);
        rready = 1'b1;
        do_switch();
        for (int i = 0; i < 7; i++) tick();
        check("pre_reset_rvalid", {31'b0, rvalid}, 32'd1);
        rready = 1'b0;
        rst_n  = 1'b0;
        tick();
        check("mid_reset_rvalid", {31'b0, rvalid}, 32'd0);
        check("mid_reset_switch_ready", {31'b0, switch_ready}, 32'd1);
        rst_n = 1'b1;
        tick();
        clear_exp();
        full_drain(0, "post_reset_a");
        full_drain(0, "post_reset_b");

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_accumulation_buffer

// File: doc/accumulation_buffer.md
# accumulation_buffer

- Double-buffered output accumulator directly downstream of the systolic array of `mac` cells.
- Captures the vector of `ofmap_out` partial sums leaving the bottom row of the array, one lane per column.
- A lane value either overwrites the stored entry or is added to it, so multiple weight tiles can be summed.
- While one bank accumulates, the other bank is drained to the output writer over a valid/ready stream.

## Interface
- `OFMAP_WIDTH`, default 8: width of one lane (one partial sum).
- `ARRAY_WIDTH`, default 4: number of lanes (array columns).
- `DEPTH`, default 16: entries per bank. Must be a power of two, ≥2.
- `ADDR_WIDTH`, default `$clog2(DEPTH)`: entry address width.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `wen`, in, 1: write a vector into the write bank this cycle.
- `waddr`, in, ADDR_WIDTH: write entry address.
- `accumulate`, in, 1: 1 = add `wdata` to the stored entry; 0 = overwrite it.
- `wdata`, in, ARRAY_WIDTH*OFMAP_WIDTH: lane i is `wdata[i*OFMAP_WIDTH +: OFMAP_WIDTH]`.
- `switch_banks`, in, 1: request to swap bank roles and start a drain.
- `switch_ready`, out, 1: drain idle; a switch is accepted this cycle.
- `rdata`, out, ARRAY_WIDTH*OFMAP_WIDTH: entry being drained.
- `rvalid`, out, 1: `rdata` is valid.
- `rready`, in, 1: downstream accepts `rdata`.

## Operation
- **Storage:** two banks of DEPTH×ARRAY_WIDTH lanes, held in flops. Register `write_bank` selects the accumulating bank; the other bank is the read bank.
- **Write:** on `wen`, each lane of `mem[write_bank][waddr]` becomes `wdata_lane`, or `stored_lane + wdata_lane` when `accumulate` is set.
  - Lane addition is modulo 2^OFMAP_WIDTH, with no carry between lanes.
  - Two's-complement sums therefore wrap correctly.
- **Drain FSM**, states IDLE and DRAIN:
  - IDLE → DRAIN when `switch_banks` is high: toggle `write_bank`, set `drain_addr` to 0.
  - In DRAIN, `rvalid` is 1 and `rdata` is `mem[read_bank][drain_addr]`.
  - On `rvalid && rready`, the drained entry is cleared to 0.
  - After that handshake, `drain_addr` increments, or the FSM returns to IDLE if `drain_addr == DEPTH-1`.
- Because entries are cleared as they are drained, a bank always returns to writing with all entries zero.
- `switch_ready` is 1 exactly in IDLE. `switch_banks` is ignored in DRAIN and is not queued.
- **Simultaneous events:**
  - `wen` and an accepted `switch_banks` in the same cycle: the write lands in the pre-switch write bank, which then becomes the read bank and is drained.
  - Writes during DRAIN always target the write bank and never disturb the drain.

## Timing
- **Write, RMW:** a write at edge k is visible to an accumulate to the same address at edge k+1. Back-to-back accumulates to one address sum every cycle with no bubbles.
- **Switch:** a switch accepted at edge k gives `rvalid` = 1 and entry 0 on `rdata` after edge k.
- **Drain rate:** one entry per cycle while `rready` is held high. A full drain takes DEPTH cycles minimum.
- **Stall:** `rdata` and `rvalid` hold stable while `rvalid && !rready`.
- **Reset values** (on any edge with `rst_n` = 0):
  - Both banks cleared to 0.
  - `write_bank` = 0, FSM in IDLE, `drain_addr` = 0.
  - `rvalid` = 0, `switch_ready` = 1, `rdata` = 0.
- Reset mid-drain aborts the drain and discards all contents.

## Structure
- Shared header holds:
  - default `OFMAP_WIDTH` and `ARRAY_WIDTH`, shared with `mac` and the array top;
  - FSM state localparams `DRAIN_IDLE` and `DRAIN_ACTIVE`.
- Sub-module `accumulation_bank`, instantiated twice. Each instance has:
  - one flop array with a read-modify-write write port;
  - a combinational read port;
  - a clear-entry port.
- The top holds the bank select, drain FSM and muxing.

## Test plan
Scenarios use the defaults `OFMAP_WIDTH`=8, `ARRAY_WIDTH`=4, `DEPTH`=16.
- **Reset:** hold `rst_n`=0 for 2 cycles → `rvalid`=0, `switch_ready`=1, `rdata`=0. A drain after release returns all zeros.
- **Overwrite then accumulate:**
  - write addr 3 with lanes {1,2,3,4}, `accumulate`=0;
  - next cycle write addr 3 with {10,10,10,10}, `accumulate`=1;
  - switch and drain with `rready`=1 → entry 3 = {11,12,13,14}, all other entries 0, `rvalid` high for exactly 16 cycles.
- **Lane wrap:** accumulate 200 onto a stored 100 in lane 0 → lane 0 = 44 and lane 1 is unaffected.
- **Backpressure:**
  - drain with `rready` toggled 1,0,0,1,...;
  - `rdata` and `rvalid` hold during the 0 cycles;
  - entries arrive in address order 0..15 with none lost or duplicated.
- **Concurrent activity:**
  - during DRAIN, `switch_banks`=1 is ignored (`switch_ready`=0);
  - writes to addr 5 meanwhile go to the new write bank;
  - after the drain completes, a second switch drains that bank → the written value appears at entry 5, and the previously drained bank reads back zero.
- **Edge cases:**
  - `wen` together with an accepted switch → that write appears in the immediate drain;
  - reset asserted at drain entry 7 → `rvalid` drops after the edge, and a subsequent drain yields all zeros.
